// File: rtl/csa_share_arb.sv
// csa_share_arb: round-robin arbiter sharing one carry-select adder
// among FIR requesters, with per-requester stored carry for chaining.
module csa_share_arb #(
   parameter int N_REQ = 4,
   parameter int W     = 16,
   parameter int IDW   = $clog2(N_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [N_REQ*W-1:0] req_a,
   input  logic [N_REQ*W-1:0] req_b,
   input  logic [N_REQ-1:0]   req_cin,
   input  logic [N_REQ-1:0]   req_chain,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [IDW-1:0]     rsp_id,
   output logic [W-1:0]       rsp_sum,
   output logic               rsp_cout
);

   localparam int LO = W / 2;
   localparam int HI = W - LO;

   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [N_REQ-1:0] carry_q, carry_d;
   logic             vld_q, vld_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [W-1:0]     sum_q, sum_d;
   logic             cout_q, cout_d;

   logic             slot_free;
   logic             hit;
   logic             accept;
   logic [IDW-1:0]   g;
   logic [IDW-1:0]   cand;

   logic [W-1:0]     a_g, b_g;
   logic             cin_g;
   logic [LO:0]      lo_s;
   logic [HI:0]      hi0, hi1;
   logic [W-1:0]     add_sum;
   logic             add_cout;

   // Rotating-priority search starting at ptr; lowest offset wins.
   always_comb begin
      slot_free = !vld_q | rsp_ready;
      hit       = 1'b0;
      g         = '0;
      cand      = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = IDW'((int'(ptr_q) + k) % N_REQ);
         if (req_valid[cand]) begin
            hit = 1'b1;
            g   = cand;
         end
      end
      accept    = hit & slot_free & rst_n;
      req_ready = '0;
      if (accept) req_ready[g] = 1'b1;
   end

   // Operand mux and carry-select add: high half precomputed for both
   // low-half carries, then selected.
   always_comb begin
      a_g      = req_a[int'(g)*W +: W];
      b_g      = req_b[int'(g)*W +: W];
      cin_g    = req_chain[g] ? carry_q[g] : req_cin[g];
      lo_s     = {1'b0, a_g[LO-1:0]} + {1'b0, b_g[LO-1:0]}
               + {{LO{1'b0}}, cin_g};
      hi0      = {1'b0, a_g[W-1:LO]} + {1'b0, b_g[W-1:LO]};
      hi1      = hi0 + {{HI{1'b0}}, 1'b1};
      add_sum  = {lo_s[LO] ? hi1[HI-1:0] : hi0[HI-1:0],
                  lo_s[LO-1:0]};
      add_cout = lo_s[LO] ? hi1[HI] : hi0[HI];
   end

   // Next state: accept loads the slot, a lone drain empties it.
   always_comb begin
      ptr_d   = ptr_q;
      carry_d = carry_q;
      vld_d   = vld_q;
      id_d    = id_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      if (accept) begin
         vld_d      = 1'b1;
         id_d       = g;
         sum_d      = add_sum;
         cout_d     = add_cout;
         carry_d[g] = add_cout;
         ptr_d      = (g == IDW'(N_REQ - 1)) ? '0 : IDW'(g + 1'b1);
      end else if (rsp_ready) begin
         vld_d = 1'b0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         carry_q <= '0;
         vld_q   <= 1'b0;
         id_q    <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         carry_q <= carry_d;
         vld_q   <= vld_d;
         id_q    <= id_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign rsp_valid = vld_q;
   assign rsp_id    = id_q;
   assign rsp_sum   = sum_q;
   assign rsp_cout  = cout_q;

endmodule

// File: tb/tb_csa_share_arb.sv
// tb_csa_share_arb: directed plus randomized checks of csa_share_arb
// against an arithmetic reference model of the arbiter and adder.
module tb_csa_share_arb;

   localparam int N = 4;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic [N-1:0]   req_cin;
   logic [N-1:0]   req_chain;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [1:0]     rsp_id;
   logic [W-1:0]   rsp_sum;
   logic           rsp_cout;

   int checks = 0;
   int errors = 0;

   int unsigned m_carry [N];
   int unsigned m_ptr;
   int unsigned m_valid;
   int unsigned m_id;
   int unsigned m_sum;
   int unsigned m_cout;
   int          last_g;

   csa_share_arb #(.N_REQ(N), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .req_chain (req_chain),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_carry[i] = 0;
      m_ptr = 0; m_valid = 0; m_id = 0; m_sum = 0; m_cout = 0;
   endtask

   task automatic set_req(input int i, input logic [15:0] a,
                          input logic [15:0] b, input logic cin,
                          input logic chain);
      req_valid[i]     = 1'b1;
      req_a[i*W +: W]  = a;
      req_b[i*W +: W]  = b;
      req_cin[i]       = cin;
      req_chain[i]     = chain;
   endtask

   // One clock: check grant before the edge, advance model, check outputs.
   task automatic cycle();
      int          g;
      int unsigned cin, full;
      logic [N-1:0] exp_rdy;
      @(negedge clk);
      g = -1;
      if (rst_n && !(m_valid != 0 && !rsp_ready)) begin
         for (int k = N - 1; k >= 0; k--)
            if (req_valid[(m_ptr + k) % N]) g = int'((m_ptr + k) % N);
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      @(posedge clk);
      last_g = g;
      if (!rst_n) begin
         model_reset();
         last_g = -1;
      end else if (g >= 0) begin
         cin  = req_chain[g] ? m_carry[g] : 32'(req_cin[g]);
         full = 32'(req_a[g*W +: W]) + 32'(req_b[g*W +: W]) + cin;
         m_sum   = full % 65536;
         m_cout  = full / 65536;
         m_id    = g;
         m_valid = 1;
         m_carry[g] = m_cout;
         m_ptr   = (g + 1) % N;
      end else if (rsp_ready) begin
         m_valid = 0;
      end
      #1;
      chk("rsp_valid", 32'(rsp_valid), m_valid);
      chk("rsp_id", 32'(rsp_id), m_id);
      chk("rsp_sum", 32'(rsp_sum), m_sum);
      chk("rsp_cout", 32'(rsp_cout), m_cout);
   endtask

   logic [15:0] hold_sum;
   logic [1:0]  hold_id;
   logic [N-1:0] pend;

   initial begin
      rst_n = 1'b0; rsp_ready = 1'b1;
      req_valid = '1; req_a = '0; req_b = '0;
      req_cin = '0; req_chain = '0;
      model_reset();
      last_g = -1;
      @(posedge clk); #1;

      // Reset held two cycles with everyone requesting
      cycle(); cycle();
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      rst_n = 1'b1;
      cycle();
      chk("first_grant", last_g, 0);

      // Single add on requester 0
      req_valid = '0;
      set_req(0, 16'h1234, 16'h0FFF, 1'b1, 1'b0);
      cycle();
      req_valid = '0;
      chk("single_sum", 32'(rsp_sum), 32'h2234);
      chk("single_cout", 32'(rsp_cout), 0);
      chk("single_id", 32'(rsp_id), 0);

      // Round-robin from a fresh pointer
      rst_n = 1'b0; cycle(); rst_n = 1'b1;
      for (int i = 0; i < N; i++)
         set_req(i, 16'(i * 100), 16'(i), 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         cycle();
         chk("rr_grant", last_g, i % N);
         chk("rr_valid", 32'(rsp_valid), 1);
      end

      // Backpressure: slot full, consumer stalled 3 cycles
      hold_sum = rsp_sum; hold_id = rsp_id;
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("bp_sum", 32'(rsp_sum), 32'(hold_sum));
         chk("bp_id", 32'(rsp_id), 32'(hold_id));
      end
      rsp_ready = 1'b1;
      cycle();
      chk("bp_next_grant", last_g, 2);

      // Per-requester carry storage
      req_valid = '0;
      set_req(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      cycle(); req_valid = '0;
      chk("ch1_sum", 32'(rsp_sum), 0);
      chk("ch1_cout", 32'(rsp_cout), 1);
      set_req(1, 16'h0001, 16'h0001, 1'b0, 1'b0);
      cycle(); req_valid = '0;
      chk("ch2_sum", 32'(rsp_sum), 2);
      chk("ch2_cout", 32'(rsp_cout), 0);
      set_req(2, 16'h0000, 16'h0000, 1'b0, 1'b1);
      cycle(); req_valid = '0;
      chk("ch3_sum", 32'(rsp_sum), 1);
      chk("ch3_id", 32'(rsp_id), 2);

      // Mid-operation reset while a response is stalled
      set_req(1, 16'h0010, 16'h0020, 1'b0, 1'b0);
      cycle(); req_valid = '0;
      rsp_ready = 1'b0;
      cycle();
      rst_n = 1'b0;
      cycle();
      chk("mrst_valid", 32'(rsp_valid), 0);
      rst_n = 1'b1; rsp_ready = 1'b1;
      set_req(0, 16'h0003, 16'h0004, 1'b0, 1'b0);
      set_req(2, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
      cycle(); req_valid[0] = 1'b0;
      chk("mrst_ptr_grant", last_g, 0);
      cycle(); req_valid = '0;
      chk("mrst_chain_sum", 32'(rsp_sum), 32'hFFFF);
      chk("mrst_chain_cout", 32'(rsp_cout), 0);

      // Randomized traffic honouring the hold-until-granted rule
      pend = '0;
      for (int n = 0; n < 400; n++) begin
         rst_n     = ($urandom_range(0, 59) != 0);
         rsp_ready = ($urandom_range(0, 9) < 7);
         for (int i = 0; i < N; i++) begin
            if (pend[i] && $urandom_range(0, 9) != 0) begin
               req_valid[i] = 1'b1;
            end else if ($urandom_range(0, 2) != 0) begin
               set_req(i,
                  ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom),
                  16'($urandom), 1'($urandom), 1'($urandom));
            end else begin
               req_valid[i] = 1'b0;
            end
         end
         cycle();
         pend = req_valid;
         if (last_g >= 0) pend[last_g] = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
